// File: rtl/cpu_step_controller.sv
// cpu_step_controller: debounced run-control FSM gating the core clock enable
module cpu_step_debounce #(
    parameter int DEBOUNCE_CYCLES = 2_500_000,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);
    localparam logic [COUNTER_WIDTH-1:0] LIMIT = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
    logic sync0, sync1, level, level_prev, differ;
    logic [COUNTER_WIDTH-1:0] count;
    assign differ = sync1 != level;
    assign press  = level & ~level_prev;
    // synchronize the raw button and accept a new level only after it has been stable long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            count      <= '0;
        end else begin
            sync0      <= button;
            sync1      <= sync0;
            level_prev <= level;
            level      <= (differ && count == LIMIT) ? sync1 : level;
            count      <= (differ && count != LIMIT) ? count + 1'b1 : '0;
        end
    end
endmodule

module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 2_500_000,
    parameter int COUNTER_WIDTH   = 32,
    parameter int BURST_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   button_step,
    input  logic                   button_run,
    input  logic                   button_halt,
    input  logic [BURST_WIDTH-1:0] burst_count,
    input  logic                   core_halted,
    output logic                   cpu_ena,
    output logic [1:0]             mode,
    output logic [15:0]            step_count
);
    localparam logic [1:0] S_HALT  = 2'b00;
    localparam logic [1:0] S_BURST = 2'b01;
    localparam logic [1:0] S_RUN   = 2'b10;

    logic step_press, run_press, halt_press;
    logic [1:0] next_mode;
    logic [BURST_WIDTH-1:0] remaining, next_remaining, burst_len;

    cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .COUNTER_WIDTH(COUNTER_WIDTH)) u_step (
        .clk(clk), .rst(rst), .button(button_step), .press(step_press)
    );
    cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .COUNTER_WIDTH(COUNTER_WIDTH)) u_run (
        .clk(clk), .rst(rst), .button(button_run), .press(run_press)
    );
    cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .COUNTER_WIDTH(COUNTER_WIDTH)) u_halt (
        .clk(clk), .rst(rst), .button(button_halt), .press(halt_press)
    );

    assign burst_len = (burst_count == '0) ? BURST_WIDTH'(1) : burst_count;

    // next state: core halt beats every press, then halt > run > step; the burst length is latched only on entry
    always_comb begin
        next_mode      = mode;
        next_remaining = remaining;
        case (mode)
            S_HALT: begin
                if (!halt_press && !core_halted && run_press) begin
                    next_mode = S_RUN;
                end else if (!halt_press && !core_halted && step_press) begin
                    next_mode      = S_BURST;
                    next_remaining = burst_len;
                end
            end
            S_BURST: begin
                next_mode      = (core_halted || halt_press) ? S_HALT :
                                 run_press                   ? S_RUN  :
                                 (remaining == BURST_WIDTH'(1)) ? S_HALT : S_BURST;
                next_remaining = (next_mode == S_BURST) ? remaining - 1'b1 : '0;
            end
            S_RUN: begin
                next_mode = (core_halted || halt_press) ? S_HALT : S_RUN;
            end
            default: begin
                next_mode      = S_HALT;
                next_remaining = '0;
            end
        endcase
    end

    // register state, the enable (high exactly while not halted) and the issued-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= S_HALT;
            remaining  <= '0;
            cpu_ena    <= 1'b0;
            step_count <= '0;
        end else begin
            mode       <= next_mode;
            remaining  <= next_remaining;
            cpu_ena    <= next_mode != S_HALT;
            step_count <= cpu_ena ? step_count + 1'b1 : step_count;
        end
    end
endmodule

// File: tb/tb_cpu_step_controller.sv
// tb_cpu_step_controller: directed checks of debounce latency, bursts, run/halt and core halt
module tb_cpu_step_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button_step = 1'b0, button_run = 1'b0, button_halt = 1'b0;
    logic [7:0] burst_count = 8'd0;
    logic core_halted = 1'b0;
    logic cpu_ena;
    logic [1:0] mode;
    logic [15:0] step_count;
    int checks = 0, errors = 0;
    int ena_cycles = 0, ena_rises = 0;
    logic ena_prev = 1'b0;
    int base_cycles, base_rises;

    cpu_step_controller #(.DEBOUNCE_CYCLES(4), .COUNTER_WIDTH(32), .BURST_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .button_step(button_step), .button_run(button_run),
        .button_halt(button_halt), .burst_count(burst_count), .core_halted(core_halted),
        .cpu_ena(cpu_ena), .mode(mode), .step_count(step_count)
    );

    always #5 clk = ~clk;

    // independent observation of the enable: total high cycles and number of separate high runs
    always @(negedge clk) begin
        if (cpu_ena === 1'b1) ena_cycles++;
        if (cpu_ena === 1'b1 && ena_prev !== 1'b1) ena_rises++;
        ena_prev = cpu_ena;
    end

    task automatic do_reset();
        rst = 1'b1;
        button_step = 1'b0; button_run = 1'b0; button_halt = 1'b0;
        core_halted = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base_cycles = ena_cycles;
        base_rises = ena_rises;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cpu_ena !== 1'b0) begin errors++; $display("FAIL reset_ena: got %b expected 0", cpu_ena); end
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b expected 00", mode); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", step_count); end
    endtask

    task automatic test_single_step();
        do_reset();
        burst_count = 8'd0;
        button_step = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++; if (cpu_ena !== (k == 7)) begin errors++; $display("FAIL single_ena edge %0d: got %b expected %b", k, cpu_ena, k == 7); end
            checks++; if (mode !== ((k == 7) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL single_mode edge %0d: got %b", k, mode); end
        end
        button_step = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", step_count); end
        checks++; if (ena_cycles - base_cycles !== 1) begin errors++; $display("FAIL single_cycles: got %0d expected 1", ena_cycles - base_cycles); end
    endtask

    task automatic test_held_through_reset();
        rst = 1'b1;
        button_step = 1'b1;
        burst_count = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) begin checks++; if (cpu_ena !== 1'b0) begin errors++; $display("FAIL held_early: got %b expected 0", cpu_ena); end end
            if (k == 7) begin checks++; if (cpu_ena !== 1'b1) begin errors++; $display("FAIL held_press: got %b expected 1", cpu_ena); end end
        end
        button_step = 1'b0;
    endtask

    task automatic test_glitch();
        int lv[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int ln[8] = '{1, 2, 3, 1, 2, 1, 3, 8};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            button_step = lv[i][0];
            for (int j = 0; j < ln[i]; j++) begin
                @(negedge clk);
                checks++; if (cpu_ena !== 1'b0) begin errors++; $display("FAIL glitch_ena seg %0d: got %b expected 0", i, cpu_ena); end
            end
        end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", step_count); end
    endtask

    task automatic test_min_pulse();
        do_reset();
        burst_count = 8'd0;
        button_step = 1'b1;
        repeat (4) @(negedge clk);
        button_step = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL min_pulse_count: got %0d expected 1", step_count); end
    endtask

    task automatic test_burst();
        do_reset();
        burst_count = 8'd5;
        button_step = 1'b1;
        repeat (10) @(negedge clk);
        button_step = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (ena_cycles - base_cycles !== 5) begin errors++; $display("FAIL burst_cycles: got %0d expected 5", ena_cycles - base_cycles); end
        checks++; if (ena_rises - base_rises !== 1) begin errors++; $display("FAIL burst_runs: got %0d expected 1", ena_rises - base_rises); end
        checks++; if (step_count !== 16'd5) begin errors++; $display("FAIL burst_count: got %0d expected 5", step_count); end
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL burst_mode: got %b expected 00", mode); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        burst_count = 8'd30;
        button_step = 1'b1;
        repeat (5) @(negedge clk);
        button_step = 1'b0;
        repeat (6) @(negedge clk);
        burst_count = 8'd3;
        button_step = 1'b1;
        repeat (6) @(negedge clk);
        button_step = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (ena_cycles - base_cycles !== 30) begin errors++; $display("FAIL repress_cycles: got %0d expected 30", ena_cycles - base_cycles); end
        checks++; if (ena_rises - base_rises !== 1) begin errors++; $display("FAIL repress_runs: got %0d expected 1", ena_rises - base_rises); end
        checks++; if (step_count !== 16'd30) begin errors++; $display("FAIL repress_count: got %0d expected 30", step_count); end
    endtask

    task automatic test_run_halt();
        do_reset();
        button_run = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 6) begin
                button_run = 1'b0;
                checks++; if (cpu_ena !== 1'b0) begin errors++; $display("FAIL run_early: got %b expected 0", cpu_ena); end
            end
            if (k == 20) button_step = 1'b1;
            if (k == 30) button_step = 1'b0;
            if (k == 7 || k == 50 || k == 100) begin
                checks++; if (cpu_ena !== 1'b1 || mode !== 2'b10) begin errors++; $display("FAIL run_active cycle %0d: got ena=%b mode=%b expected 1/10", k, cpu_ena, mode); end
            end
        end
        button_halt = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin checks++; if (cpu_ena !== 1'b1) begin errors++; $display("FAIL halt_early: got %b expected 1", cpu_ena); end end
            if (k == 7) begin checks++; if (cpu_ena !== 1'b0 || mode !== 2'b00) begin errors++; $display("FAIL halt_stop: got ena=%b mode=%b expected 0/00", cpu_ena, mode); end end
        end
        button_halt = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (step_count !== 16'd100) begin errors++; $display("FAIL run_count: got %0d expected 100", step_count); end
        checks++; if (ena_cycles - base_cycles !== 100) begin errors++; $display("FAIL run_cycles: got %0d expected 100", ena_cycles - base_cycles); end
    endtask

    task automatic test_priority();
        do_reset();
        burst_count = 8'd3;
        button_run = 1'b1;
        button_step = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin button_run = 1'b0; button_step = 1'b0; end
        end
        checks++; if (mode !== 2'b10 || cpu_ena !== 1'b1) begin errors++; $display("FAIL prio_run_step: got mode=%b ena=%b expected 10/1", mode, cpu_ena); end
    endtask

    task automatic test_core_halted();
        do_reset();
        burst_count = 8'd4;
        button_run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 6) button_run = 1'b0;
        end
        core_halted = 1'b1;
        @(negedge clk);
        checks++; if (mode !== 2'b00 || cpu_ena !== 1'b0) begin errors++; $display("FAIL corehalt_stop: got mode=%b ena=%b expected 00/0", mode, cpu_ena); end
        button_step = 1'b1;
        repeat (6) @(negedge clk);
        button_step = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (ena_cycles - base_cycles !== 6) begin errors++; $display("FAIL corehalt_cycles: got %0d expected 6", ena_cycles - base_cycles); end
        checks++; if (step_count !== 16'd6) begin errors++; $display("FAIL corehalt_count: got %0d expected 6", step_count); end
        core_halted = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (step_count !== 16'd6 || mode !== 2'b00) begin errors++; $display("FAIL corehalt_dropped: got count=%0d mode=%b expected 6/00", step_count, mode); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        burst_count = 8'd200;
        button_step = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) button_step = 1'b0;
        end
        checks++; if (cpu_ena !== 1'b1 || mode !== 2'b01) begin errors++; $display("FAIL midburst_active: got ena=%b mode=%b expected 1/01", cpu_ena, mode); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (cpu_ena !== 1'b0 || mode !== 2'b00 || step_count !== 16'd0) begin errors++; $display("FAIL midburst_reset: got ena=%b mode=%b count=%0d expected 0/00/0", cpu_ena, mode, step_count); end
        button_run = 1'b1;
        button_halt = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 6) begin button_run = 1'b0; button_halt = 1'b0; end
            checks++; if (cpu_ena !== 1'b0) begin errors++; $display("FAIL run_halt_together cycle %0d: got %b expected 0", k, cpu_ena); end
        end
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL run_halt_mode: got %b expected 00", mode); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_held_through_reset();
        test_glitch();
        test_min_pulse();
        test_burst();
        test_back_to_back();
        test_run_halt();
        test_priority();
        test_core_halted();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
